// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: ALU op encodings,
// flag bit positions and the lookahead group width.
package cla_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam int GRP_W = 4;

endpackage

// File: rtl/cla_blk.sv
// Combinational BLK_W-bit carry-lookahead block built from 4-bit groups; produces
// both candidate sums (block carry-in 0 and 1) plus block propagate/generate.
module cla_blk
    import cla_pkg::*;
#(
    parameter int BLK_W = 16
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    output logic [BLK_W-1:0] sum0,
    output logic [BLK_W-1:0] sum1,
    output logic             p,
    output logic             g
);

    localparam int NGRP = BLK_W / GRP_W;

    logic [BLK_W-1:0] pb;
    logic [BLK_W-1:0] gb;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;

    // Group carries come from the group-level lookahead; bit carries only inside a group.
    function automatic logic [BLK_W-1:0] blk_sum(
        input logic             ci,
        input logic [BLK_W-1:0] pv,
        input logic [BLK_W-1:0] gv,
        input logic [NGRP-1:0]  gpv,
        input logic [NGRP-1:0]  ggv
    );
        logic [NGRP-1:0]  cg;
        logic [BLK_W-1:0] s;
        logic             c;
        cg[0] = ci;
        for (int m = 1; m < NGRP; m++) begin
            cg[m] = ggv[m-1] | (gpv[m-1] & cg[m-1]);
        end
        s = '0;
        for (int m = 0; m < NGRP; m++) begin
            c = cg[m];
            for (int j = 0; j < GRP_W; j++) begin
                if (j > 0) begin
                    c = gv[m*GRP_W+j-1] | (pv[m*GRP_W+j-1] & c);
                end
                s[m*GRP_W+j] = pv[m*GRP_W+j] ^ c;
            end
        end
        return s;
    endfunction

    always_comb begin
        logic gl;
        logic bl;
        pb = a ^ b;
        gb = a & b;
        gp = '0;
        gg = '0;
        for (int m = 0; m < NGRP; m++) begin
            gl = 1'b0;
            bl = 1'b1;
            for (int j = 0; j < GRP_W; j++) begin
                gl = gb[m*GRP_W+j] | (pb[m*GRP_W+j] & gl);
                bl = bl & pb[m*GRP_W+j];
            end
            gg[m] = gl;
            gp[m] = bl;
        end
        gl = 1'b0;
        for (int m = 0; m < NGRP; m++) begin
            gl = gg[m] | (gp[m] & gl);
        end
        g    = gl;
        p    = &gp;
        sum0 = blk_sum(1'b0, pb, gb, gp, gg);
        sum1 = blk_sum(1'b1, pb, gb, gp, gg);
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-select/lookahead adder-subtractor with valid/ready
// handshake and N/Z/C/V flags.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NBLK = WIDTH / BLK_W;

    logic [WIDTH-1:0]            bb;
    logic                        c0;
    logic [NBLK-1:0][BLK_W-1:0]  blk_sum0;
    logic [NBLK-1:0][BLK_W-1:0]  blk_sum1;
    logic [NBLK-1:0]             blk_p;
    logic [NBLK-1:0]             blk_g;
    logic                        cmsb0;
    logic                        cmsb1;

    logic                        v1;
    logic                        v2;
    logic [NBLK-1:0][BLK_W-1:0]  s1_sum0;
    logic [NBLK-1:0][BLK_W-1:0]  s1_sum1;
    logic [NBLK-1:0]             s1_p;
    logic [NBLK-1:0]             s1_g;
    logic                        s1_c0;
    logic                        s1_cmsb0;
    logic                        s1_cmsb1;

    logic                        s1_load;
    logic                        s2_load;
    logic [NBLK:0]               c_blk;
    logic [WIDTH-1:0]            sel_sum;
    logic                        msb_c;

    assign bb = (sub == ALU_OP_SUB) ? ~b : b;
    assign c0 = cin ^ (sub == ALU_OP_SUB);

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        cla_blk #(.BLK_W(BLK_W)) u_blk (
            .a    (a[k*BLK_W +: BLK_W]),
            .b    (bb[k*BLK_W +: BLK_W]),
            .sum0 (blk_sum0[k]),
            .sum1 (blk_sum1[k]),
            .p    (blk_p[k]),
            .g    (blk_g[k])
        );
    end

    // Carry into the MSB bit recovered from the top block's candidate sums.
    assign cmsb0 = a[WIDTH-1] ^ bb[WIDTH-1] ^ blk_sum0[NBLK-1][BLK_W-1];
    assign cmsb1 = a[WIDTH-1] ^ bb[WIDTH-1] ^ blk_sum1[NBLK-1][BLK_W-1];

    assign s2_load   = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_c0    <= 1'b0;
            s1_cmsb0 <= 1'b0;
            s1_cmsb1 <= 1'b0;
        end else begin
            v1 <= s1_load | (v1 & ~s2_load);
            if (s1_load) begin
                s1_sum0  <= blk_sum0;
                s1_sum1  <= blk_sum1;
                s1_p     <= blk_p;
                s1_g     <= blk_g;
                s1_c0    <= c0;
                s1_cmsb0 <= cmsb0;
                s1_cmsb1 <= cmsb1;
            end
        end
    end

    // Second-level lookahead across blocks selects each block's precomputed sum.
    always_comb begin
        c_blk    = '0;
        sel_sum  = '0;
        c_blk[0] = s1_c0;
        for (int k = 0; k < NBLK; k++) begin
            c_blk[k+1] = s1_g[k] | (s1_p[k] & c_blk[k]);
            sel_sum[k*BLK_W +: BLK_W] = c_blk[k] ? s1_sum1[k] : s1_sum0[k];
        end
        msb_c = c_blk[NBLK-1] ? s1_cmsb1 : s1_cmsb0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else begin
            v2 <= s2_load | (v2 & ~out_ready);
            if (s2_load) begin
                sum  <= sel_sum;
                cout <= c_blk[NBLK];
                ovf  <= msb_c ^ c_blk[NBLK];
                zero <= (sel_sum == '0);
                neg  <= sel_sum[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed corner cases, a stalled stream,
// async reset with beats in flight, latency, and a random stream against a+b.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int WIDTH = 32;
    localparam int BLK_W = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [3:0]       flags;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic [3:0]       obs_flags;

    int               checks = 0;
    int               failures = 0;
    exp_t             sb[$];
    int               stall_cycles = 0;
    bit               rand_ready = 0;
    bit               saw_full = 0;
    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_sum;
    logic [3:0]       prev_flags;

    cla_pipe_adder #(.WIDTH(WIDTH), .BLK_W(BLK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] mk_flags(input logic n, input logic z, input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

    assign obs_flags = mk_flags(neg, zero, cout, ovf);

    // Reference: plain wide addition of effective operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic ci);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] yy;
        logic             cm;
        exp_t             e;
        yy      = s ? ~y : y;
        ext     = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci ^ s};
        cm      = x[WIDTH-1] ^ yy[WIDTH-1] ^ ext[WIDTH-1];
        e.sum   = ext[WIDTH-1:0];
        e.flags = mk_flags(ext[WIDTH-1], ext[WIDTH-1:0] == '0, ext[WIDTH], cm ^ ext[WIDTH]);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : (stall_cycles == 0);
        if (stall_cycles > 0) stall_cycles--;
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s, input logic ci, input exp_t e);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        cin      = ci;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                next_cycle();
                in_valid = 1'b0;
                return;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout observed=in_ready_low expected=accept");
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) return;
            next_cycle();
        end
        checks++;
        failures++;
        $display("[TB] FAIL drain_timeout observed=%0d_pending expected=0", sb.size());
    endtask

    // Output monitor: sampled mid-cycle, so a visible handshake is the one taken at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !out_ready && !in_ready) saw_full = 1'b1;
            if (out_valid && prev_stall) begin
                check_val("hold_sum", sum, prev_sum);
                check_val("hold_flags", WIDTH'(obs_flags), WIDTH'(prev_flags));
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_flags = obs_flags;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL unexpected_beat observed=%h expected=none", sum);
                end else begin
                    e = sb.pop_front();
                    check_val("sum", sum, e.sum);
                    check_val("flags", WIDTH'(obs_flags), WIDTH'(e.flags));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("rst_out_valid", WIDTH'(out_valid), '0);
        check_val("rst_sum", sum, '0);
        check_val("rst_flags", WIDTH'(obs_flags), '0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

        $display("[TB] directed corner cases");
        apply_stimulus(32'h0000FFFF, 32'h1, 1'b0, 1'b0, '{32'h00010000, mk_flags(0, 0, 0, 0)});
        apply_stimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h00000000, mk_flags(0, 1, 1, 0)});
        apply_stimulus(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h80000000, mk_flags(1, 0, 0, 1)});
        apply_stimulus(32'h5, 32'h7, 1'b1, 1'b0, '{32'hFFFFFFFE, mk_flags(1, 0, 0, 0)});
        apply_stimulus(32'h80000000, 32'h1, 1'b1, 1'b0, '{32'h7FFFFFFF, mk_flags(0, 0, 1, 1)});
        apply_stimulus(32'h5, 32'h2, 1'b1, 1'b1, '{32'h00000002, mk_flags(0, 0, 1, 0)});
        wait_drain();

        $display("[TB] stream with backpressure");
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            x = 32'h11111111 * i + 32'h0000FFF0;
            y = 32'h00000013 * i;
            if (i == 3) stall_cycles = 3;
            apply_stimulus(x, y, i[0], i[1], model(x, y, i[0], i[1]));
        end
        wait_drain();
        check_val("in_ready_dropped", WIDTH'(saw_full), WIDTH'(1));

        $display("[TB] reset with beats in flight");
        stall_cycles = 10;
        apply_stimulus(32'h12345678, 32'h1, 1'b0, 1'b0, model(32'h12345678, 32'h1, 1'b0, 1'b0));
        apply_stimulus(32'h00000009, 32'h3, 1'b1, 1'b0, model(32'h00000009, 32'h3, 1'b1, 1'b0));
        check_val("inflight_valid", WIDTH'(out_valid), WIDTH'(1));
        rst_n = 1'b0;
        #1;
        check_val("async_out_valid", WIDTH'(out_valid), '0);
        check_val("async_sum", sum, '0);
        check_val("async_flags", WIDTH'(obs_flags), '0);
        sb.delete();
        stall_cycles = 0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_val("post_rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        repeat (3) next_cycle();
        check_val("no_stale_valid", WIDTH'(out_valid), '0);

        $display("[TB] latency");
        in_valid = 1'b1;
        a        = 32'h00000001;
        b        = 32'h00000002;
        sub      = 1'b0;
        cin      = 1'b0;
        @(negedge clk);
        check_val("lat_accept", WIDTH'(in_ready), WIDTH'(1));
        sb.push_back('{32'h00000003, mk_flags(0, 0, 0, 0)});
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("lat_cycle1", WIDTH'(out_valid), '0);
        @(negedge clk);
        check_val("lat_cycle2", WIDTH'(out_valid), WIDTH'(1));
        next_cycle();
        wait_drain();

        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            logic             s;
            logic             ci;
            x  = $urandom;
            y  = $urandom;
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            if (i % 7 == 0) y = ~x;
            apply_stimulus(x, y, s, ci, model(x, y, s, ci));
        end
        rand_ready = 1'b0;
        next_cycle();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
